// File: rtl/uart_tx_sequencer_if.sv
// Avalon-MM bus between the UART TX sequencer and the JTAG UART slave.
interface uart_tx_sequencer_if;
  logic [15:0] av_address;
  logic        av_read;
  logic        av_write;
  logic [15:0] av_writedata;
  logic [15:0] av_readdata;
  logic        av_waitrequest;

  modport master (
    output av_address,
    output av_read,
    output av_write,
    output av_writedata,
    input  av_readdata,
    input  av_waitrequest
  );

  modport slave (
    input  av_address,
    input  av_read,
    input  av_write,
    input  av_writedata,
    output av_readdata,
    output av_waitrequest
  );
endinterface

// File: rtl/uart_tx_sequencer.sv
// Byte FIFO drained to a JTAG UART over Avalon-MM with polled write credit.
// Optional waitrequest watchdog: define UART_TX_SEQUENCER_TIMEOUT_EN.
module uart_tx_sequencer #(
  parameter int          DEPTH     = 16,
  parameter logic [15:0] DATA_ADDR = 16'h0100,
  parameter logic [15:0] CTRL_ADDR = 16'h0106,
  parameter int          POLL_GAP  = 16,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             wr_data,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   busy,
  output logic                   err,
  uart_tx_sequencer_if.master    av
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    POLL,
    GAP,
    WRITE
  } state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic [15:0]   credit;
  logic [GW-1:0] gap_cnt;
  logic          flush_pend;

  logic strobe;
  logic rd_done;
  logic wr_done;
  logic to;
  logic xfer_end;
  logic flush_now;
  logic push;
  logic pop;

  assign strobe   = av.av_read | av.av_write;
  assign rd_done  = av.av_read & ~av.av_waitrequest;
  assign wr_done  = av.av_write & ~av.av_waitrequest;
  assign xfer_end = rd_done | wr_done | to;
  // A flush never aborts a bus cycle; it lands when the cycle ends.
  assign flush_now = (flush & ~strobe)
                   | ((flush | flush_pend) & xfer_end);

  assign wr_ready   = count != FULL;
  assign push       = wr_valid & wr_ready & ~flush_now;
  assign pop        = wr_done | (to & av.av_write);
  assign fifo_count = count;
  assign busy       = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush_now) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      av.av_read      <= 1'b0;
      av.av_write     <= 1'b0;
      av.av_address   <= '0;
      av.av_writedata <= '0;
      credit          <= '0;
      gap_cnt         <= '0;
      flush_pend      <= 1'b0;
    end else if (flush_now) begin
      state       <= IDLE;
      av.av_read  <= 1'b0;
      av.av_write <= 1'b0;
      credit      <= '0;
      gap_cnt     <= '0;
      flush_pend  <= 1'b0;
    end else begin
      if (flush) flush_pend <= 1'b1;
      unique case (state)
        IDLE: begin
          if (count != '0) begin
            if (credit != '0) begin
              state           <= WRITE;
              av.av_write     <= 1'b1;
              av.av_address   <= DATA_ADDR;
              av.av_writedata <= {8'h00, mem[rd_ptr]};
            end else begin
              state         <= POLL;
              av.av_read    <= 1'b1;
              av.av_address <= CTRL_ADDR;
            end
          end
        end
        POLL: begin
          if (to) begin
            av.av_read <= 1'b0;
            credit     <= '0;
            gap_cnt    <= '0;
            state      <= GAP;
          end else if (rd_done) begin
            av.av_read <= 1'b0;
            credit     <= av.av_readdata;
            gap_cnt    <= '0;
            state      <= (av.av_readdata == '0) ? GAP : IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            state         <= POLL;
            av.av_read    <= 1'b1;
            av.av_address <= CTRL_ADDR;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        WRITE: begin
          if (to) begin
            av.av_write <= 1'b0;
            state       <= IDLE;
          end else if (wr_done) begin
            av.av_write <= 1'b0;
            credit      <= (credit != '0) ? credit - 1'b1 : '0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_TX_SEQUENCER_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);

  logic [WW-1:0] wd;

  // Counts consecutive stalled cycles; any unstalled cycle rearms it.
  assign to = strobe & av.av_waitrequest
            & (wd == WW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd  <= '0;
      err <= 1'b0;
    end else begin
      wd <= (strobe & av.av_waitrequest) ? wd + 1'b1 : '0;
      if (flush_now) err <= 1'b0;
      else if (to) err <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT == 0);
  assign to  = 1'b0;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer with a behavioural JTAG UART slave.
module tb_uart_tx_sequencer;
  localparam int DEPTH    = 16;
  localparam int POLL_GAP = 16;
  localparam int TIMEOUT  = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       flush;
  logic [4:0] fifo_count;
  logic       busy;
  logic       err;

  uart_tx_sequencer_if av ();

  uart_tx_sequencer #(
    .DEPTH    (DEPTH),
    .POLL_GAP (POLL_GAP),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_data    (wr_data),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .flush      (flush),
    .fifo_count (fifo_count),
    .busy       (busy),
    .err        (err),
    .av         (av)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q [$];

  int wait_n   = 0;
  int wspace   = 0;
  int ws_fixed = -1;
  bit stall_wr = 0;
  int cyc      = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  int rd_len   = 0;
  int wr_len   = 0;
  int rd_last  = 0;
  int rd_prev  = 0;
  int wr_last  = 0;
  int wr_prev  = 0;

  task automatic slave_proc();
    logic [15:0] paddr;
    logic [15:0] pdata;
    logic [7:0]  e;
    bit          pstall;
    int          wcnt;
    pstall = 0;
    wcnt   = 0;
    paddr  = '0;
    pdata  = '0;
    forever begin
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (av.av_read === 1'b1 && av.av_write === 1'b1) begin
        n_err++;
        $display("FAIL strobes: read=1 write=1, required never both");
      end
      if (pstall && (av.av_read || av.av_write)) begin
        n_cmp++;
        if (av.av_address !== paddr || av.av_writedata !== pdata) begin
          n_err++;
          $display("FAIL stall_hold: addr=%h data=%h required %h %h",
                   av.av_address, av.av_writedata, paddr, pdata);
        end
      end
      if (av.av_read || av.av_write) begin
        if ((av.av_write && stall_wr) || wcnt < wait_n) begin
          av.av_waitrequest = 1'b1;
          wcnt++;
        end else begin
          av.av_waitrequest = 1'b0;
          if (av.av_read) begin
            av.av_readdata = (ws_fixed >= 0) ? 16'(ws_fixed) : 16'(wspace);
            n_cmp++;
            if (av.av_address !== 16'h0106) begin
              n_err++;
              $display("FAIL read_addr: got %h required 0106", av.av_address);
            end
            rd_len  = wcnt + 1;
            n_rd++;
            rd_prev = rd_last;
            rd_last = cyc;
          end else begin
            n_cmp++;
            if (exp_q.size() == 0) begin
              n_err++;
              $display("FAIL write_unexpected: got data %h required no write",
                       av.av_writedata);
            end else begin
              e = exp_q.pop_front();
              if (av.av_writedata !== {8'h00, e} || av.av_address !== 16'h0100) begin
                n_err++;
                $display("FAIL write_data: got addr %h data %h required 0100 %h",
                         av.av_address, av.av_writedata, {8'h00, e});
              end
            end
            wr_len  = wcnt + 1;
            n_wr++;
            wr_prev = wr_last;
            wr_last = cyc;
            if (wspace > 0) wspace--;
          end
          wcnt = 0;
        end
      end else begin
        av.av_waitrequest = 1'b0;
        wcnt = 0;
      end
      pstall = (av.av_read || av.av_write) && av.av_waitrequest;
      paddr  = av.av_address;
      pdata  = av.av_writedata;
    end
  endtask

  task automatic push(input logic [7:0] b, output bit acc);
    wr_data  = b;
    wr_valid = 1'b1;
    acc      = wr_ready;
    if (acc) exp_q.push_back(b);
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound, output bit ok);
    int t = 0;
    while (busy && t < bound) begin
      @(negedge clk);
      t++;
    end
    ok = !busy;
  endtask

  task automatic do_flush();
    int t = 0;
    while ((av.av_read || av.av_write) && t < 100) begin
      @(negedge clk);
      t++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    exp_q.delete();
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    wr_valid = 1'b1;
    wr_data  = 8'hAA;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({av.av_read, av.av_write, av.av_address, av.av_writedata} !== 34'h0 ||
        fifo_count !== 5'd0 || busy !== 1'b0 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: rd=%b wr=%b addr=%h wd=%h cnt=%0d busy=%b err=%b required all 0",
               av.av_read, av.av_write, av.av_address, av.av_writedata,
               fifo_count, busy, err);
    end
    n_cmp++;
    if (wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_wr_ready: got %b required 1", wr_ready);
    end
    n_cmp++;
    if (dut.credit !== 16'h0) begin
      n_err++;
      $display("FAIL reset_credit: got %0d required 0", dut.credit);
    end
    wr_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (fifo_count !== 5'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_push: cnt=%0d busy=%b required 0 0", fifo_count, busy);
    end
  endtask

  task automatic test_single();
    int n0;
    bit acc;
    bit ok;
    wspace = 64;
    wait_n = 2;
    n0     = n_wr;
    push(8'h31, acc);
    wait_idle(200, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL single_idle: busy=%b required 0", busy);
    end
    n_cmp++;
    if (rd_len != 3) begin
      n_err++;
      $display("FAIL single_read_len: got %0d required 3", rd_len);
    end
    n_cmp++;
    if (n_wr - n0 != 1) begin
      n_err++;
      $display("FAIL single_writes: got %0d required 1", n_wr - n0);
    end
    n_cmp++;
    if (dut.credit !== 16'd63) begin
      n_err++;
      $display("FAIL single_credit: got %0d required 63", dut.credit);
    end
    n_cmp++;
    if (fifo_count !== 5'd0) begin
      n_err++;
      $display("FAIL single_count: got %0d required 0", fifo_count);
    end
  endtask

  task automatic test_full();
    int n0;
    int r0;
    int acc_n;
    int t;
    bit acc;
    do_flush();
    wspace = 0;
    wait_n = 0;
    n0     = n_wr;
    acc_n  = 0;
    for (int i = 0; i < 16; i++) begin
      push(8'(8'h40 + i), acc);
      if (acc) acc_n++;
    end
    n_cmp++;
    if (acc_n != 16 || wr_ready !== 1'b0 || fifo_count !== 5'd16) begin
      n_err++;
      $display("FAIL full_fill: acc=%0d ready=%b cnt=%0d required 16 0 16",
               acc_n, wr_ready, fifo_count);
    end
    push(8'h99, acc);
    n_cmp++;
    if (acc !== 1'b0 || fifo_count !== 5'd16) begin
      n_err++;
      $display("FAIL full_ignore: acc=%b cnt=%0d required 0 16", acc, fifo_count);
    end
    r0 = n_rd;
    t  = 0;
    while (n_rd < r0 + 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (n_rd < r0 + 2 || rd_last - rd_prev != POLL_GAP + 1) begin
      n_err++;
      $display("FAIL full_poll_gap: got %0d required %0d",
               rd_last - rd_prev, POLL_GAP + 1);
    end
    wspace = 4;
    t = 0;
    while (n_wr < n0 + 4 && t < 300) begin
      @(negedge clk);
      t++;
    end
    r0 = n_rd;
    t  = 0;
    while (n_rd < r0 + 2 && t < 300) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (n_wr - n0 != 4 || n_rd < r0 + 2) begin
      n_err++;
      $display("FAIL full_credit_writes: writes=%0d polls=%0d required 4 2",
               n_wr - n0, n_rd - r0);
    end
    n_cmp++;
    if (fifo_count !== 5'd12 || exp_q.size() != 12) begin
      n_err++;
      $display("FAIL full_remaining: cnt=%0d q=%0d required 12 12",
               fifo_count, exp_q.size());
    end
  endtask

  task automatic test_flush_write();
    int n0;
    int t;
    bit acc;
    bit ok;
    do_flush();
    wspace = 10;
    wait_n = 5;
    n0     = n_wr;
    push(8'h55, acc);
    push(8'h66, acc);
    t = 0;
    while (!av.av_write && t < 200) begin
      @(negedge clk);
      t++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || n_wr - n0 != 1 || wr_len != 6) begin
      n_err++;
      $display("FAIL flush_inflight: idle=%b writes=%0d len=%0d required 1 1 6",
               ok, n_wr - n0, wr_len);
    end
    n_cmp++;
    if (fifo_count !== 5'd0 || dut.credit !== 16'd0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL flush_state: cnt=%0d credit=%0d busy=%b required 0 0 0",
               fifo_count, dut.credit, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit acc;
    bit ok;
    do_flush();
    wspace = 100;
    wait_n = 0;
    for (int i = 0; i < 4; i++) push(8'(8'hB0 + i), acc);
    wait_idle(200, ok);
    n_cmp++;
    if (!ok || wr_last - wr_prev != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL b2b_rate: spacing=%0d q=%0d required 2 0",
               wr_last - wr_prev, exp_q.size());
    end
    push(8'hC3, acc);
    n_cmp++;
    if (av.av_write !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: av_write=%b at N+1 required 0", av.av_write);
    end
    @(negedge clk);
    n_cmp++;
    if (av.av_write !== 1'b1 || av.av_writedata !== 16'h00C3) begin
      n_err++;
      $display("FAIL latency_n2: av_write=%b data=%h at N+2 required 1 00c3",
               av.av_write, av.av_writedata);
    end
    wait_idle(100, ok);
  endtask

  task automatic test_wrap();
    int n0;
    int sent;
    int t;
    bit acc;
    bit ok;
    do_flush();
    ws_fixed = 0;
    wait_n   = 0;
    n0       = n_wr;
    sent     = 0;
    for (int i = 0; i < 3; i++) begin
      push(8'(sent + 1), acc);
      if (acc) sent++;
    end
    ws_fixed = 8;
    t = 0;
    while (!av.av_write && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (av.av_write !== 1'b1 || fifo_count !== 5'd3) begin
      n_err++;
      $display("FAIL wrap_pre: write=%b cnt=%0d required 1 3", av.av_write, fifo_count);
    end
    push(8'(sent + 1), acc);
    if (acc) sent++;
    n_cmp++;
    if (fifo_count !== 5'd3) begin
      n_err++;
      $display("FAIL wrap_push_pop: cnt=%0d required 3", fifo_count);
    end
    t = 0;
    while (sent < 40 && t < 1000) begin
      push(8'(sent + 1), acc);
      if (acc) sent++;
      t++;
    end
    wait_idle(2000, ok);
    n_cmp++;
    if (!ok || n_wr - n0 != 40 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL wrap_drain: writes=%0d q=%0d required 40 0",
               n_wr - n0, exp_q.size());
    end
    ws_fixed = -1;
  endtask

  task automatic test_timeout();
    int n0;
    int n;
    int t;
    bit acc;
    bit ok;
    do_flush();
    wspace   = 10;
    wait_n   = 0;
    stall_wr = 1'b1;
    n0       = n_wr;
    push(8'h77, acc);
    t = 0;
    while (!av.av_write && t < 200) begin
      @(negedge clk);
      t++;
    end
    n = 0;
    while (av.av_write && n < 50) begin
      n++;
      @(negedge clk);
    end
`ifdef UART_TX_SEQUENCER_TIMEOUT_EN
    n_cmp++;
    if (n != TIMEOUT || err !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_trip: len=%0d err=%b required %0d 1", n, err, TIMEOUT);
    end
    n_cmp++;
    if (fifo_count !== 5'd0 || n_wr != n0) begin
      n_err++;
      $display("FAIL timeout_drop: cnt=%0d writes=%0d required 0 0",
               fifo_count, n_wr - n0);
    end
    if (exp_q.size() != 0) exp_q.delete();
    stall_wr = 1'b0;
    do_flush();
    n_cmp++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_clear: err=%b required 0", err);
    end
`else
    n_cmp++;
    if (n != 50 || err !== 1'b0) begin
      n_err++;
      $display("FAIL stall_wait: len=%0d err=%b required 50 0", n, err);
    end
    stall_wr = 1'b0;
    wait_idle(100, ok);
    n_cmp++;
    if (!ok || n_wr - n0 != 1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stall_release: writes=%0d q=%0d required 1 0",
               n_wr - n0, exp_q.size());
    end
`endif
  endtask

  initial begin
    av.av_readdata    = '0;
    av.av_waitrequest = 1'b0;
    fork
      slave_proc();
    join_none
    test_reset();
    test_single();
    test_full();
    test_flush_write();
    test_back_to_back();
    test_wrap();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_sequencer.md
Name: uart_tx_sequencer

Overview:
- Hardware sequencer that takes bytes from the CPU (or any byte source), buffers them in a small FIFO, and drains them to the JTAG UART over the Avalon-MM master port.
- Removes the CPU's spin on av_waitrequest and its blind writes.
- Tracks UART write space by polling the UART control register, and caches it as a credit count so no write is issued into a full UART.

Parameters:
- DEPTH, 16, FIFO depth in bytes; power of 2, minimum 2.
- DATA_ADDR, 16'h0100, Avalon address of the JTAG UART data register.
- CTRL_ADDR, 16'h0106, Avalon address of the control-register high half; read data = WSPACE.
- POLL_GAP, 16, idle cycles between polls when WSPACE reads 0; minimum 1.
- TIMEOUT, 1024, waitrequest watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- wr_data  in  8  byte to enqueue.
- wr_valid  in  1  enqueue request; accepted when wr_valid && wr_ready.
- wr_ready  out  1  FIFO not full.
- flush  in  1  synchronous; discards FIFO contents and credit.
- fifo_count  out  $clog2(DEPTH)+1  bytes currently queued.
- busy  out  1  FIFO non-empty or a bus transaction is in progress.
- err  out  1  sticky timeout flag; cleared by flush.
- av_address  out  16  Avalon address.
- av_read  out  1  Avalon read strobe.
- av_write  out  1  Avalon write strobe.
- av_writedata  out  16  {8'h00, byte}.
- av_readdata  in  16  Avalon read data.
- av_waitrequest  in  1  slave stall.

Behaviour:
Reset state:
- One clock; reset is asynchronous and active-low.
- Under reset: av_read=0, av_write=0, av_address=0, av_writedata=0, fifo_count=0, busy=0, err=0, credit=0, state IDLE.
- wr_ready is combinational (fifo_count != DEPTH), so it reads 1 during reset.

FIFO:
- Circular buffer with read and write pointers plus a count.
- Push when wr_valid && wr_ready. A push while full is ignored with no error; it is not accepted even if a pop occurs in the same cycle.
- Pop occurs on the cycle a data write completes (av_write && !av_waitrequest).
- Simultaneous push and pop leaves the count unchanged.

Credit:
- 16-bit counter, loaded from av_readdata at poll completion.
- Decremented at each write completion.
- Never wraps below 0.

FSM states: IDLE, POLL, GAP, WRITE.
- IDLE: if FIFO non-empty and credit != 0, go to WRITE; if FIFO non-empty and credit == 0, go to POLL.
- POLL: av_read=1, av_address=CTRL_ADDR. Hold while av_waitrequest=1. On completion: credit <= av_readdata, deassert av_read; go to GAP if av_readdata == 0, else IDLE.
- GAP: count POLL_GAP cycles, then go to POLL.
- WRITE: av_write=1, av_address=DATA_ADDR, av_writedata = FIFO head. Hold while stalled. On completion: pop, credit--, go to IDLE.

Avalon and timing rules:
- Strobes, address and writedata are registered and stay stable for as long as av_waitrequest=1.
- av_read and av_write are never both high.
- Latency: a byte pushed in cycle N into an empty FIFO with credit > 0 in IDLE drives av_write in cycle N+2.
- Sustained throughput is 1 byte per 2 cycles with zero wait states (WRITE and IDLE alternate).

Flush:
- Outside a transaction: takes effect next cycle. Count, pointers and credit go to 0, err clears, state goes to IDLE.
- During POLL or WRITE: flush is latched pending. The bus transaction completes normally (Avalon forbids abort), then the flush is applied. A byte whose write was in flight is still written.
- A push in the same cycle as an applied flush is dropped.

busy = (fifo_count != 0) || (state != IDLE).

Optional Feature:
Macro: UART_TX_SEQUENCER_TIMEOUT_EN.
- Defined: a watchdog counts consecutive cycles in POLL or WRITE with av_waitrequest=1. On reaching TIMEOUT, deassert the strobe and set err=1.
  - In WRITE, pop and drop the byte.
  - In POLL, set credit=0 and go to GAP.
  - The counter resets on every transaction start.
- Undefined: no watchdog logic; err is tied to 0; stalls wait indefinitely.

Test Plan:
1. Reset with wr_valid=1 held -> all outputs at reset values, wr_ready=1; no push recorded until reset_n rises.
2. Push 0x31 with credit 0, slave returns WSPACE=64 after 2 wait states -> av_read with address 0x0106 held 3 cycles, then av_write with address 0x0100 and writedata 0x0031; credit becomes 63; fifo_count ends at 0.
3. Push 16 bytes back-to-back with WSPACE=0 -> wr_ready=0 after the 16th byte and a 17th push is ignored. Polls are spaced POLL_GAP+1 cycles apart. After WSPACE changes to 4: exactly 4 writes in order, then polling resumes; fifo_count=12.
4. Assert flush during WRITE with av_waitrequest held 5 cycles -> write completes with the original byte, then fifo_count=0, credit=0, busy=0.
5. Simultaneous push and pop at fifo_count=3 -> fifo_count stays 3; output byte order is preserved across pointer wrap (push 40 bytes total, WSPACE=8 per poll).
6. With UART_TX_SEQUENCER_TIMEOUT_EN and TIMEOUT=8, hold av_waitrequest=1 during WRITE -> av_write drops after 8 cycles, err=1, byte dropped; flush then clears err.
